// File: rtl/gtech_xor_reduce_pipe.sv
`default_nettype none
// ============================================================================
// Module   : gtech_xor_reduce_pipe
// Brief    : Pipelined multi-channel XOR reduction, per-beat or per-packet;
//            EXP/ERR check ports exist only with GTECH_XOR_CHECK_EN defined.
// Revision : 1.0
// ============================================================================
module gtech_xor_reduce_pipe #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int STAGES   = 2
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CHANNELS*WIDTH-1:0]   a,
    input  logic                        mode,
    input  logic                        in_last,
`ifdef GTECH_XOR_CHECK_EN
    input  logic [CHANNELS-1:0]         exp,
    output logic [CHANNELS-1:0]         err,
`endif
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CHANNELS-1:0]         z,
    output logic                        out_last
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int PAD    = 1 << LEVELS;

    typedef logic [CHANNELS-1:0][PAD-1:0] word_t;

    // Tree levels completed by the logic feeding register k.
    function automatic int depth(input int k);
        if (k == 0) return 0;
        if (k >= STAGES - 1) return LEVELS;
        return (LEVELS * k) / (STAGES - 1);
    endfunction

    function automatic word_t fold(input word_t v, input int from, input int to);
        word_t cur;
        word_t nxt;
        cur = v;
        for (int lv = 0; lv < LEVELS; lv++) begin
            if (lv >= from && lv < to) begin
                nxt = '0;
                for (int c = 0; c < CHANNELS; c++) begin
                    for (int i = 0; i < PAD / 2; i++) begin
                        nxt[c][i] = cur[c][2*i] ^ cur[c][2*i+1];
                    end
                end
                cur = nxt;
            end
        end
        return cur;
    endfunction

    word_t                  in_word;
    logic                   ready_out;
    logic                   head_valid;
    word_t                  head_word;
    logic                   head_mode;
    logic                   head_last;
    logic                   move;
    logic [CHANNELS-1:0]    parity;
    logic [CHANNELS-1:0]    acc;
`ifdef GTECH_XOR_CHECK_EN
    logic [CHANNELS-1:0]    head_exp;
    logic [CHANNELS-1:0]    exp_hold;
`endif

    always_comb begin
        in_word = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            in_word[c][WIDTH-1:0] = a[c*WIDTH +: WIDTH];
        end
    end

    assign ready_out = ~out_valid | out_ready;

    generate
        if (STAGES > 1) begin : g_pipe
            logic [STAGES-1:1]  valid;
            logic [STAGES-1:1]  smode;
            logic [STAGES-1:1]  slast;
            logic [STAGES-1:1]  ready;
            logic               chain;
            word_t              sword [1:STAGES-1];
`ifdef GTECH_XOR_CHECK_EN
            logic [CHANNELS-1:0] sexp [1:STAGES-1];
`endif

            // A stage can take a beat when it is empty or its content moves on.
            always_comb begin
                chain = ready_out;
                ready = '0;
                for (int k = STAGES - 1; k >= 1; k--) begin
                    chain    = ~valid[k] | chain;
                    ready[k] = chain;
                end
            end

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    valid <= '0;
                end else begin
                    if (ready[1]) valid[1] <= in_valid;
                    for (int k = 2; k < STAGES; k++) begin
                        if (ready[k]) valid[k] <= valid[k-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (ready[1]) begin
                    sword[1] <= fold(in_word, depth(0), depth(1));
                    smode[1] <= mode;
                    slast[1] <= in_last;
`ifdef GTECH_XOR_CHECK_EN
                    sexp[1]  <= exp;
`endif
                end
                for (int k = 2; k < STAGES; k++) begin
                    if (ready[k]) begin
                        sword[k] <= fold(sword[k-1], depth(k-1), depth(k));
                        smode[k] <= smode[k-1];
                        slast[k] <= slast[k-1];
`ifdef GTECH_XOR_CHECK_EN
                        sexp[k]  <= sexp[k-1];
`endif
                    end
                end
            end

            assign in_ready   = ready[1];
            assign head_valid = valid[STAGES-1];
            assign head_word  = sword[STAGES-1];
            assign head_mode  = smode[STAGES-1];
            assign head_last  = slast[STAGES-1];
`ifdef GTECH_XOR_CHECK_EN
            assign head_exp   = sexp[STAGES-1];
`endif
        end else begin : g_direct
            assign in_ready   = ready_out;
            assign head_valid = in_valid;
            assign head_word  = in_word;
            assign head_mode  = mode;
            assign head_last  = in_last;
`ifdef GTECH_XOR_CHECK_EN
            assign head_exp   = exp;
`endif
        end
    endgenerate

    // Folding preserves total XOR, so reducing the whole padded word
    // finishes whatever part of the tree is left.
    always_comb begin
        parity = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            parity[c] = ^head_word[c];
        end
    end

    assign move = head_valid & ready_out;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            z         <= '0;
            out_last  <= 1'b0;
            acc       <= '0;
`ifdef GTECH_XOR_CHECK_EN
            exp_hold  <= '0;
`endif
        end else begin
            if (out_ready) out_valid <= 1'b0;
            if (move) begin
                if (!head_mode) begin
                    out_valid <= 1'b1;
                    z         <= parity;
                    out_last  <= 1'b0;
`ifdef GTECH_XOR_CHECK_EN
                    exp_hold  <= head_exp;
`endif
                end else if (!head_last) begin
                    acc <= acc ^ parity;
                end else begin
                    out_valid <= 1'b1;
                    z         <= acc ^ parity;
                    out_last  <= 1'b1;
                    acc       <= '0;
`ifdef GTECH_XOR_CHECK_EN
                    exp_hold  <= head_exp;
`endif
                end
            end
        end
    end

`ifdef GTECH_XOR_CHECK_EN
    assign err = (z ^ exp_hold) & {CHANNELS{out_valid}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_gtech_xor_reduce_pipe.sv
`default_nettype none
// Randomized scoreboard bench for gtech_xor_reduce_pipe (WIDTH=8, CHANNELS=4).
module tb_gtech_xor_reduce_pipe;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int STAGES   = 2;

    typedef struct packed {
        logic       last;
        logic [3:0] z;
        logic [3:0] e;
    } ent_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic        mode = 1'b0;
    logic        in_last = 1'b0;
    logic [3:0]  exp_in = '0;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  z;
    logic        out_last;
`ifdef GTECH_XOR_CHECK_EN
    logic [3:0]  err;
`endif

    logic [1:0]  rdy_mode = 2'd1;
    logic        rnd_bit = 1'b1;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cycle = 0;
    ent_t        sb[$];
    logic [3:0]  macc = '0;
    logic        hold = 1'b0;
    logic [3:0]  hz;
    logic        hl;

    gtech_xor_reduce_pipe #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .STAGES   (STAGES)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .mode      (mode),
        .in_last   (in_last),
`ifdef GTECH_XOR_CHECK_EN
        .exp       (exp_in),
        .err       (err),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;
    always @(posedge clk) rnd_bit <= ($urandom_range(0, 3) != 0);
    assign out_ready = (rdy_mode == 2'd2) ? rnd_bit : rdy_mode[0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: parity is the odd/even count of ones per byte lane.
    function automatic void model_accept(input logic [31:0] d, input logic m,
                                         input logic l, input logic [3:0] e);
        logic [3:0] p;
        for (int c = 0; c < CHANNELS; c++) p[c] = ($countones(d[c*8 +: 8]) % 2) == 1;
        if (!m) begin
            sb.push_back({1'b0, p, e});
        end else if (!l) begin
            macc = macc ^ p;
        end else begin
            sb.push_back({1'b1, macc ^ p, e});
            macc = '0;
        end
    endfunction

    task automatic send(input logic [31:0] d, input logic m, input logic l, input logic [3:0] e);
        int   guard;
        logic took;
        guard = 0;
        took  = 1'b0;
        a = d; mode = m; in_last = l; exp_in = e; in_valid = 1'b1;
        while (!took && guard < 300) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            guard++;
        end
        if (took) model_accept(d, m, l, e);
        else check("send_timeout", 32'd1, 32'd0);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        do begin
            @(posedge clk);
            g++;
        end while (sb.size() != 0 && g < 1000);
        if (g >= 1000) check("drain_timeout", 32'd1, 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        sb.delete();
        macc = '0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    always @(negedge clk) begin
        ent_t ent;
        if (!rstn) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_z", {28'd0, z}, {28'd0, hz});
                check("hold_last", {31'd0, out_last}, {31'd0, hl});
            end
            hold = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", 32'd1, 32'd0);
                    end else begin
                        ent = sb.pop_front();
                        check("z", {28'd0, z}, {28'd0, ent.z});
                        check("out_last", {31'd0, out_last}, {31'd0, ent.last});
`ifdef GTECH_XOR_CHECK_EN
                        check("err", {28'd0, err}, {28'd0, ent.z ^ ent.e});
`endif
                    end
                end else begin
                    hold = 1'b1;
                    hz   = z;
                    hl   = out_last;
                end
            end
        end
    end

    initial begin
        int   lat;
        int   nacc;
        int   c0;
        logic took;

        // Reset with a pending beat: nothing may be accepted or emitted.
        in_valid = 1'b1;
        a = 32'h0103_07FF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_z", {28'd0, z}, 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Latency and value of a single per-beat result.
        send(32'h0103_07FF, 1'b0, 1'b0, 4'b1000);
        lat = 0;
        forever begin
            @(negedge clk);
            if (out_valid || lat > 20) break;
            @(posedge clk);
            lat++;
        end
        check("latency", lat, STAGES - 1);
        check("mode0_z", {28'd0, z}, 32'b1010);
        check("mode0_last", {31'd0, out_last}, 32'd0);
`ifdef GTECH_XOR_CHECK_EN
        check("mode0_err", {28'd0, err}, 32'b0010);
`endif
        @(posedge clk);
        #1;

        // Back-to-back beats at full rate.
        c0 = cycle;
        for (int i = 0; i < 8; i++) send($urandom, 1'b0, 1'b0, 4'($urandom));
        check("throughput_cycles", cycle - c0, 8);
        drain();

        // Packets, second starting from a cleared accumulator.
        send(32'h0101_0101, 1'b1, 1'b0, 4'h0);
        send(32'h0001_0001, 1'b1, 1'b0, 4'h0);
        send(32'h0000_0001, 1'b1, 1'b1, 4'hB);
        send(32'h0000_0003, 1'b1, 1'b0, 4'h0);
        send(32'h8000_00FE, 1'b1, 1'b1, 4'h5);
        drain();

        // Backpressure: output full, pipe fills, input stalls.
        rdy_mode = 2'd0;
        nacc = 0;
        in_valid = 1'b1;
        mode = 1'b0;
        in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a = $urandom;
            exp_in = 4'($urandom);
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            if (took) begin
                model_accept(a, 1'b0, 1'b0, exp_in);
                nacc++;
            end
            #1;
        end
        check("bp_accepted", nacc, STAGES);
        @(negedge clk);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        rdy_mode = 2'd1;
        drain();

        // Per-beat result interleaved inside a packet.
        send(32'h0F00_0001, 1'b1, 1'b0, 4'h0);
        send(32'h1234_5678, 1'b0, 1'b1, 4'h3);
        send(32'h0000_0100, 1'b1, 1'b1, 4'h9);
        drain();

        // Reset mid-packet discards the partial accumulation.
        send(32'hFF01_0101, 1'b1, 1'b0, 4'h0);
        send(32'h0101_0000, 1'b1, 1'b0, 4'h0);
        do_reset();
        send(32'h0300_0107, 1'b1, 1'b1, 4'h0);
        drain();

        // Random traffic with random output backpressure.
        rdy_mode = 2'd2;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send($urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 4'($urandom));
        end
        rdy_mode = 2'd1;
        send(32'h0, 1'b1, 1'b1, 4'h0);
        drain();
        check("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
